imm_extend_stage: RTL

//  Registered, multi-mode immediate generator for the decode stage. Takes a 32-bit instruction word plus a mode select.

---
 rtl/imm_pkg.sv | 24 ++
 rtl/imm_ext_comb.sv | 34 +++
 rtl/imm_extend_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator: mode encodings
// and the default-width payload record.
package imm_pkg;

  localparam int IMM_MODE_W = 3;

  localparam logic [IMM_MODE_W-1:0] IMM_SEXT16 = 3'd0;
  localparam logic [IMM_MODE_W-1:0] IMM_ZEXT16 = 3'd1;
  localparam logic [IMM_MODE_W-1:0] IMM_SHAMT  = 3'd2;
  localparam logic [IMM_MODE_W-1:0] IMM_LUI    = 3'd3;
  localparam logic [IMM_MODE_W-1:0] IMM_BOFF   = 3'd4;
  localparam logic [IMM_MODE_W-1:0] IMM_JIDX   = 3'd5;

  localparam logic [15:0] IMM_ERR_CNT_MAX = 16'hFFFF;

  // Payload for the default 32-bit operand / 5-bit tag build; stages built
  // with other widths declare a local record with the same field order.
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        err;
  } imm_payload_t;

endpackage

// File: rtl/imm_ext_comb.sv
// Pure combinational instruction-word -> DATA_W immediate extender.
// Shared with the branch unit, so it carries no state.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]           instr,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic [DATA_W-1:0]     imm,
  output logic                  err
);

  logic [15:0] i16;
  logic        unused_hi;

  assign i16       = instr[15:0];
  assign unused_hi = ^instr[31:26];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (mode)
      IMM_SEXT16: imm = {{(DATA_W-16){i16[15]}}, i16};
      IMM_ZEXT16: imm[15:0] = i16;
      IMM_SHAMT:  imm[4:0]  = instr[10:6];
      IMM_LUI:    imm[31:0] = {i16, 16'h0000};
      IMM_BOFF:   imm = {{(DATA_W-18){i16[15]}}, i16, 2'b00};
      IMM_JIDX:   imm[27:0] = {instr[25:0], 2'b00};
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-generator stage: one output register plus a one-entry
// skid so the consumer can stall without dropping words, and an error counter.
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_imm,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err,
  output logic [15:0]           err_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } pay_t;

  pay_t        in_pay, out_q, skid_q;
  logic        out_vld_q, skid_vld_q;
  logic [15:0] err_cnt_q;
  logic        accept, load;

  imm_ext_comb #(.DATA_W(DATA_W)) u_ext (
    .instr (in_instr),
    .mode  (in_mode),
    .imm   (in_pay.imm),
    .err   (in_pay.err)
  );
  assign in_pay.tag = in_tag;

  // rst_n gates in_ready so nothing looks acceptable while held in reset.
  assign in_ready = rst_n & ~skid_vld_q & ~flush;
  assign accept   = in_valid & in_ready;
  assign load     = ~out_vld_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (load) begin
      // A full skid blocks accept, so skid and input never compete here.
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else if (accept) begin
        out_q     <= in_pay;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_pay;
      skid_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (accept && in_pay.err && err_cnt_q != IMM_ERR_CNT_MAX)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign out_valid = out_vld_q;
  assign out_imm   = out_q.imm;
  assign out_tag   = out_q.tag;
  assign out_err   = out_q.err;
  assign err_cnt   = err_cnt_q;

endmodule
